dm_rmw_ctrl: RTL and testbench



---
 rtl/dm_rmw_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dm_rmw_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_rmw_ctrl.sv
// dm_rmw_ctrl: data-memory access controller in front of a single-port SRAM
// that has no byte-write support.
//
// Access types:
//   - Full-word stores are written straight through with no stall.
//   - Sub-word stores read the old word, merge the new bytes in, and write
//     the result back. This takes two cycles with one stall cycle.
//   - Loads take one registered read, also with one stall cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting requests; full-word stores complete here
// LD    | read data is on iMemRData; present it on oRData
// RMW   | old word is on iMemRData; write the merged word to rAddr
//
// All memory-side outputs and oStall are combinational and are gated by
// rst_n. While reset is held low nothing reaches the SRAM, so an RMW in
// progress is aborted before its write.
module dm_rmw_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [11:0] iAddr,
  input  logic [31:0] iData,
  input  logic [3:0]  iBE,
  output logic        oStall,
  output logic [31:0] oRData,
  output logic        oRValid,
  output logic        oMemCe,
  output logic        oMemWe,
  output logic [11:0] oMemAddr,
  output logic [31:0] oMemWData,
  input  logic [31:0] iMemRData,
  output logic [15:0] oStallCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LD   = 2'd1,
    RMW  = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] rAddr;
  logic [31:0] rData;
  logic [3:0]  rBE;
  logic [15:0] stallCnt;

  logic        stall;
  logic        rValid;
  logic [31:0] rDataOut;
  logic        memCe;
  logic        memWe;
  logic [11:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] merged;

  logic        isFullStore;
  logic        isPartStore;
  logic        isLoad;

  assign isFullStore = iReq &&  iWe && (iBE == 4'b1111);
  assign isPartStore = iReq &&  iWe && (iBE != 4'b1111) && (iBE != 4'b0000);
  assign isLoad      = iReq && !iWe;

  // Byte merge: enabled lanes come from the latched store data, the others
  // come from the old word just read back.
  always_comb begin
    merged = '0;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = rBE[k] ? rData[8*k +: 8] : iMemRData[8*k +: 8];
    end
  end

  // Decode the memory-side controls and the stall from state and inputs.
  always_comb begin
    stall    = 1'b0;
    rValid   = 1'b0;
    rDataOut = '0;
    memCe    = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWData = '0;
    case (state)
      IDLE: begin
        if (isFullStore) begin
          memCe    = 1'b1;
          memWe    = 1'b1;
          memAddr  = iAddr;
          memWData = iData;
        end else if (isPartStore || isLoad) begin
          memCe   = 1'b1;
          memAddr = iAddr;
          stall   = 1'b1;
        end
      end
      LD: begin
        rValid   = 1'b1;
        rDataOut = iMemRData;
      end
      RMW: begin
        memCe    = 1'b1;
        memWe    = 1'b1;
        memAddr  = rAddr;
        memWData = merged;
      end
      default: ;
    endcase
  end

  // Reset masks every output so nothing leaks to the SRAM or the pipeline.
  always_comb begin
    oStall    = rst_n & stall;
    oRValid   = rst_n & rValid;
    oRData    = rst_n ? rDataOut : 32'h0;
    oMemCe    = rst_n & memCe;
    oMemWe    = rst_n & memWe;
    oMemAddr  = rst_n ? memAddr  : 12'h0;
    oMemWData = rst_n ? memWData : 32'h0;
    oStallCnt = rst_n ? stallCnt : 16'h0;
  end

  // State transitions and request latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rAddr <= '0;
      rData <= '0;
      rBE   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (isPartStore) begin
            rAddr <= iAddr;
            rData <= iData;
            rBE   <= iBE;
            state <= RMW;
          end else if (isLoad) begin
            rAddr <= iAddr;
            state <= LD;
          end
        end
        LD:      state <= IDLE;
        RMW:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// tb_dm_rmw_ctrl: directed bench for dm_rmw_ctrl with a behavioural SRAM.
module tb_dm_rmw_ctrl;

  logic        clk;
  logic        rst_n;
  logic        iReq;
  logic        iWe;
  logic [11:0] iAddr;
  logic [31:0] iData;
  logic [3:0]  iBE;
  logic        oStall;
  logic [31:0] oRData;
  logic        oRValid;
  logic        oMemCe;
  logic        oMemWe;
  logic [11:0] oMemAddr;
  logic [31:0] oMemWData;
  logic [31:0] iMemRData;
  logic [15:0] oStallCnt;

  logic [31:0] mem [0:4095];
  int          nChecks;
  int          nFails;

  dm_rmw_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iReq      (iReq),
    .iWe       (iWe),
    .iAddr     (iAddr),
    .iData     (iData),
    .iBE       (iBE),
    .oStall    (oStall),
    .oRData    (oRData),
    .oRValid   (oRValid),
    .oMemCe    (oMemCe),
    .oMemWe    (oMemWe),
    .oMemAddr  (oMemAddr),
    .oMemWData (oMemWData),
    .iMemRData (iMemRData),
    .oStallCnt (oStallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous SRAM: one-cycle read latency, word writes only.
  always @(posedge clk) begin
    if (oMemCe) begin
      if (oMemWe) mem[oMemAddr] <= oMemWData;
      else        iMemRData     <= mem[oMemAddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [11:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    iReq  = req;
    iWe   = we;
    iAddr = addr;
    iData = data;
    iBE   = be;
  endtask

  // Two-cycle load: stall in the first cycle, data in the second.
  task automatic doLoad(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, 1'b0, addr, 32'h0, 4'b0000);
    #1;
    chk({tag, " stall"}, {31'b0, oStall}, 32'h1);
    chk({tag, " rdata0"}, oRData, 32'h0);
    @(negedge clk);
    #1;
    chk({tag, " rvalid"}, {31'b0, oRValid}, 32'h1);
    chk({tag, " rdata"}, oRData, exp);
    chk({tag, " nostall"}, {31'b0, oStall}, 32'h0);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    iMemRData = '0;
    mem[12'h020] <= 32'h11223344;
    mem[12'h030] <= 32'hCAFEF00D;
    mem[12'h040] <= 32'h55667788;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 12'h010, 32'hFFFFFFFF, 4'b1111);

    // Reset: outputs held at zero even with a request present.
    #2;
    chk("rst ce",    {31'b0, oMemCe},  32'h0);
    chk("rst we",    {31'b0, oMemWe},  32'h0);
    chk("rst stall", {31'b0, oStall},  32'h0);
    chk("rst cnt",   {16'b0, oStallCnt}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word store goes straight through.
    @(negedge clk);
    drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 4'b1111);
    #1;
    chk("fw stall", {31'b0, oStall}, 32'h0);
    chk("fw ce",    {31'b0, oMemCe}, 32'h1);
    chk("fw we",    {31'b0, oMemWe}, 32'h1);
    chk("fw addr",  {20'b0, oMemAddr}, 32'h010);
    chk("fw wdata", oMemWData, 32'hDEADBEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    chk("fw mem", mem[12'h010], 32'hDEADBEEF);
    doLoad("ld010", 12'h010, 32'hDEADBEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    #1;
    chk("ld cnt", {16'b0, oStallCnt}, 32'd1);

    // Byte store to lane 2.
    @(negedge clk);
    drive(1'b1, 1'b1, 12'h020, 32'h00AB0000, 4'b0100);
    #1;
    chk("b2 stall", {31'b0, oStall}, 32'h1);
    chk("b2 rd ce", {31'b0, oMemCe}, 32'h1);
    chk("b2 rd we", {31'b0, oMemWe}, 32'h0);
    @(negedge clk);
    #1;
    chk("b2 wr we",   {31'b0, oMemWe}, 32'h1);
    chk("b2 wr addr", {20'b0, oMemAddr}, 32'h020);
    chk("b2 wr data", oMemWData, 32'h11AB3344);
    chk("b2 nostall", {31'b0, oStall}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    #1;
    chk("b2 mem", mem[12'h020], 32'h11AB3344);
    chk("b2 cnt", {16'b0, oStallCnt}, 32'd2);

    // Upper halfword store followed immediately by a load of the same word.
    @(negedge clk);
    drive(1'b1, 1'b1, 12'h030, 32'h12340000, 4'b1100);
    #1;
    chk("hw stall", {31'b0, oStall}, 32'h1);
    @(negedge clk);
    #1;
    chk("hw wr data", oMemWData, 32'h1234F00D);
    doLoad("hw ld", 12'h030, 32'h1234F00D);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    #1;
    chk("hw cnt", {16'b0, oStallCnt}, 32'd4);

    // No-op store and idle cycles.
    @(negedge clk);
    drive(1'b1, 1'b1, 12'h050, 32'h12345678, 4'b0000);
    #1;
    chk("nop ce",    {31'b0, oMemCe}, 32'h0);
    chk("nop stall", {31'b0, oStall}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 12'h050, 32'h12345678, 4'b1111);
      #1;
      chk("idle ce",    {31'b0, oMemCe}, 32'h0);
      chk("idle stall", {31'b0, oStall}, 32'h0);
    end
    chk("nop cnt", {16'b0, oStallCnt}, 32'd4);
    chk("nop mem", mem[12'h050], 32'h0);

    // Reset asserted during the RMW write cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 12'h040, 32'h000000AA, 4'b0001);
    @(negedge clk);
    #1;
    chk("rmw pre we", {31'b0, oMemWe}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rmw rst ce",    {31'b0, oMemCe}, 32'h0);
    chk("rmw rst we",    {31'b0, oMemWe}, 32'h0);
    chk("rmw rst wdata", oMemWData, 32'h0);
    chk("rmw rst stall", {31'b0, oStall}, 32'h0);
    chk("rmw rst cnt",   {16'b0, oStallCnt}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    chk("rmw rst mem", mem[12'h040], 32'h55667788);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rmw post stall", {31'b0, oStall}, 32'h0);
    chk("rmw post cnt",   {16'b0, oStallCnt}, 32'h0);
    doLoad("rmw post ld", 12'h040, 32'h55667788);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    #1;
    chk("rmw post ld cnt", {16'b0, oStallCnt}, 32'd1);

    // Counter saturation, starting close to the top.
    force dut.stallCnt = 16'hFFFC;
    @(negedge clk);
    release dut.stallCnt;
    #1;
    chk("sat preload", {16'b0, oStallCnt}, 32'h0000FFFC);
    for (int i = 0; i < 3; i++) doLoad("sat ld", 12'h010, 32'hDEADBEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    #1;
    chk("sat top", {16'b0, oStallCnt}, 32'h0000FFFF);
    for (int i = 0; i < 2; i++) doLoad("sat ld2", 12'h020, 32'h11AB3344);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 32'h0, 4'b0000);
    #1;
    chk("sat hold", {16'b0, oStallCnt}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
